// File: rtl/rsa_modexp.sv
// rsa_modexp: modular exponentiation m = c^d mod n by left-to-right
// square-and-multiply, one modular multiply per clock cycle.
//
// Optional build macro RSA_CONST_TIME_EN:
//   undefined -> MUL is visited only for set exponent bits, so the run
//                length depends on popcount(d).
//   defined   -> MUL follows every SQR. The product is always formed, but
//                it only lands in acc when the exponent bit is set;
//                otherwise it goes to a dummy register. The run length is
//                then 4*WIDTH+1 cycles for every exponent.
// The numeric result is the same in both builds.
module rsa_modexp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] c,
  input  logic [2*WIDTH-1:0] d,
  input  logic [2*WIDTH-1:0] n,
  output logic [2*WIDTH-1:0] m,
  output logic               busy,
  output logic               finish,
  output logic               err
);

  localparam int DW = 2 * WIDTH;
  localparam int PW = 4 * WIDTH;
  localparam int IW = $clog2(DW);

  typedef enum logic [1:0] {
    IDLE,
    SQR,
    MUL,
    DONE
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   exp_q;
  logic [DW-1:0]   base_q;
  logic [DW-1:0]   mod_q;
  logic [DW-1:0]   acc_q;
  logic [IW-1:0]   idx_q;
  logic [DW-1:0]   m_q;
  logic            busy_q;
  logic            finish_q;
  logic            err_q;
`ifdef RSA_CONST_TIME_EN
  logic [DW-1:0]   dummy_q;
`endif

  logic [DW-1:0]   mulOperand;
  logic [PW-1:0]   product;
  logic [DW-1:0]   accProd_d;
  logic [DW-1:0]   baseInit_d;
  logic [DW-1:0]   accInit_d;
  logic            expBit;
  logic            lastBit;

  // Shared modular multiplier: squares acc in SQR, multiplies by base in MUL.
  // A zero modulus never reaches SQR/MUL, but it is guarded so the divider
  // never sees a zero divisor.
  always_comb begin
    mulOperand = (state_q == MUL) ? base_q : acc_q;
    product    = PW'(acc_q) * PW'(mulOperand);
    accProd_d  = '0;
    if (mod_q != '0) begin
      accProd_d = DW'(product % PW'(mod_q));
    end
    expBit  = exp_q[idx_q];
    lastBit = (idx_q == '0);
  end

  // Initial operand values on an accepted start: the base is reduced first
  // so acc and base both stay below the modulus, and 1 mod n is 0 for n<=1.
  always_comb begin
    baseInit_d = '0;
    accInit_d  = '0;
    if (n != '0) begin
      baseInit_d = c % n;
    end
    if (n > DW'(1)) begin
      accInit_d = DW'(1);
    end
  end

  // Control FSM with registered outputs; finish is a one-cycle pulse raised
  // as DONE is left, so it appears together with the new result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      base_q   <= '0;
      mod_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      m_q      <= '0;
      busy_q   <= 1'b0;
      finish_q <= 1'b0;
      err_q    <= 1'b0;
`ifdef RSA_CONST_TIME_EN
      dummy_q  <= '0;
`endif
    end else begin
      finish_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            exp_q  <= d;
            mod_q  <= n;
            base_q <= baseInit_d;
            acc_q  <= accInit_d;
            idx_q  <= IW'(DW - 1);
            busy_q <= 1'b1;
            err_q  <= 1'b0;
            if (n == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= SQR;
            end
          end
        end

        SQR: begin
          acc_q <= accProd_d;
`ifdef RSA_CONST_TIME_EN
          state_q <= MUL;
`else
          if (expBit) begin
            state_q <= MUL;
          end else if (lastBit) begin
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
`endif
        end

        MUL: begin
`ifdef RSA_CONST_TIME_EN
          if (expBit) begin
            acc_q <= accProd_d;
          end else begin
            dummy_q <= accProd_d;
          end
`else
          acc_q <= accProd_d;
`endif
          if (lastBit) begin
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q - IW'(1);
            state_q <= SQR;
          end
        end

        DONE: begin
          m_q      <= acc_q;
          finish_q <= 1'b1;
          busy_q   <= 1'b0;
          err_q    <= (mod_q == '0);
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m      = m_q;
  assign busy   = busy_q;
  assign finish = finish_q;
  assign err    = err_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Testbench for rsa_modexp (WIDTH=8): table-driven result/latency vectors
// plus hand-written handshake, reset-abort and self-composed pair sequences.
module tb_rsa_modexp;

  localparam int W  = 8;
  localparam int DW = 2 * W;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] c;
  logic [DW-1:0] d;
  logic [DW-1:0] n;
  logic [DW-1:0] m;
  logic          busy;
  logic          finish;
  logic          err;

  logic          start2;
  logic [DW-1:0] c2;
  logic [DW-1:0] d2;
  logic [DW-1:0] n2;
  logic [DW-1:0] m2;
  logic          busy2;
  logic          finish2;
  logic          err2;

  int checks;
  int passes;

  typedef struct {
    string         name;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [DW-1:0] n;
    logic [DW-1:0] expM;
    logic          expErr;
    int            kDefault;
  } vec_t;

  vec_t vecs[9];

  rsa_modexp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c(c), .d(d), .n(n),
    .m(m), .busy(busy), .finish(finish), .err(err)
  );

  rsa_modexp #(.WIDTH(W)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .c(c2), .d(d2), .n(n2),
    .m(m2), .busy(busy2), .finish(finish2), .err(err2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int expLatency(input logic [DW-1:0] nv, input int kDef);
`ifdef RSA_CONST_TIME_EN
    return (nv == '0) ? 1 : (4 * W + 1);
`else
    return kDef;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    checks++;
    if (act === expv) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Starts one operation on dut; returns the finish cycle (0 if none within
  // the budget) and the m/err values seen with finish.
  task automatic launch(input logic [DW-1:0] cv, input logic [DW-1:0] dv,
                        input logic [DW-1:0] nv, output int kSeen,
                        output logic [DW-1:0] mSeen, output logic errSeen,
                        output logic busyAfterStart, output logic errAfterStart);
    @(negedge clk);
    c = cv; d = dv; n = nv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busyAfterStart = busy;
    errAfterStart  = err;
    kSeen   = 0;
    mSeen   = '0;
    errSeen = 1'b0;
    if (finish) begin
      kSeen = 0;
    end
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        kSeen   = cyc;
        mSeen   = m;
        errSeen = err;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int            k;
    logic [DW-1:0] mv;
    logic          ev;
    logic          bs;
    logic          es;
    launch(v.c, v.d, v.n, k, mv, ev, bs, es);
    checkOutput({v.name, ".busyAfterStart"}, 32'(bs), 32'd1);
    checkOutput({v.name, ".errCleared"}, 32'(es), 32'd0);
    checkOutput({v.name, ".latency"}, 32'(k), 32'(expLatency(v.n, v.kDefault)));
    checkOutput({v.name, ".m"}, 32'(mv), 32'(v.expM));
    checkOutput({v.name, ".err"}, 32'(ev), 32'(v.expErr));
    checkOutput({v.name, ".busyAtFinish"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    checkOutput({v.name, ".finishPulse"}, 32'(finish), 32'd0);
    checkOutput({v.name, ".mHeld"}, 32'(m), 32'(v.expM));
  endtask

  initial begin
    int            finCount;
    int            finCyc;
    int            k1;
    int            k2;
    logic [DW-1:0] mAt;

    checks = 0;
    passes = 0;
    start = 1'b0; c = '0; d = '0; n = '0;
    start2 = 1'b0; c2 = '0; d2 = '0; n2 = '0;

    vecs[0] = '{"decrypt",   16'd2790, 16'd2753, 16'd3233, 16'd65,   1'b0, 22};
    vecs[1] = '{"encrypt",   16'd65,   16'd17,   16'd3233, 16'd2790, 1'b0, 19};
    vecs[2] = '{"expZero",   16'd123,  16'd0,    16'd3233, 16'd1,    1'b0, 17};
    vecs[3] = '{"modOne",    16'd5,    16'd3,    16'd1,    16'd0,    1'b0, 19};
    vecs[4] = '{"baseOver",  16'd4000, 16'd1,    16'd3233, 16'd767,  1'b0, 18};
    vecs[5] = '{"baseZero",  16'd0,    16'd5,    16'd3233, 16'd0,    1'b0, 19};
    vecs[6] = '{"modZero",   16'd5,    16'd7,    16'd0,    16'd0,    1'b1, 1};
    vecs[7] = '{"twoPow10",  16'd2,    16'd10,   16'd1000, 16'd24,   1'b0, 19};
    vecs[8] = '{"square",    16'd7,    16'd2,    16'd50,   16'd49,   1'b0, 18};

    rst_n = 1'b0;
    #23;
    checkOutput("reset.m", 32'(m), 32'd0);
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.finish", 32'(finish), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Re-pulsed start with other operands while busy must be ignored.
    @(negedge clk);
    c = 16'd2790; d = 16'd2753; n = 16'd3233; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finCount = 0;
    finCyc   = 0;
    mAt      = '0;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk);
      #1;
      if (finish) begin
        finCount++;
        finCyc = cyc;
        mAt    = m;
      end
      start = (cyc == 4) || (cyc == 9);
      if (start) begin
        c = 16'd11 + 16'(cyc); d = 16'd3; n = 16'd77;
      end
    end
    start = 1'b0;
    checkOutput("handshake.finishCount", 32'(finCount), 32'd1);
    checkOutput("handshake.latency", 32'(finCyc), 32'(expLatency(16'd3233, 22)));
    checkOutput("handshake.m", 32'(mAt), 32'd65);

    // Reset in the middle of a run aborts with no finish.
    @(negedge clk);
    c = 16'd2790; d = 16'd2753; n = 16'd3233; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #2;
    checkOutput("abort.m", 32'(m), 32'd0);
    checkOutput("abort.busy", 32'(busy), 32'd0);
    checkOutput("abort.finish", 32'(finish), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    finCount = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      #1;
      if (finish) finCount++;
    end
    checkOutput("abort.noFinish", 32'(finCount), 32'd0);
    applyStimulus(vecs[0]);

    // Self-composed pair: same c and n, different exponents.
    @(negedge clk);
    c  = 16'd2790; d  = 16'd2753; n  = 16'd3233; start  = 1'b1;
    c2 = 16'd2790; d2 = 16'd3;    n2 = 16'd3233; start2 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    start2 = 1'b0;
    k1 = 0;
    k2 = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk);
      #1;
      if (finish && k1 == 0) k1 = cyc;
      if (finish2 && k2 == 0) k2 = cyc;
    end
    checkOutput("pair.latencyA", 32'(k1), 32'(expLatency(16'd3233, 22)));
    checkOutput("pair.latencyB", 32'(k2), 32'(expLatency(16'd3233, 19)));
    checkOutput("pair.mA", 32'(m), 32'd65);
    checkOutput("pair.mB", 32'(m2), 32'd296);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
Name: rsa_modexp

Overview:
- Consumer end of the key-generation flow: takes a modulus n and exponent d (or e) and computes m = c^d mod n by left-to-right square-and-multiply.
- Used for decryption (c, d, n) and encryption (m, e, n), and as the victim datapath for timing side-channel analysis.
- Sits downstream of KeyGen and is instantiated in self-composed pairs, like KeyGen, for non-interference checks.

Parameters:
- WIDTH, 8, prime width. Key, modulus and data width is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse. Sampled only in IDLE.
- c  input  2*WIDTH  base (ciphertext or plaintext). Latched on accepted start.
- d  input  2*WIDTH  exponent (private or public key). Latched on accepted start.
- n  input  2*WIDTH  modulus. Latched on accepted start.
- m  output  2*WIDTH  result. Valid from finish onward; held until the next accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- finish  output  1  single-cycle done pulse, registered.
- err  output  1  set with finish when the latched n==0. Cleared on the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; m=0, busy=0, finish=0, err=0; internal exp/base/mod/acc/idx cleared.
- Reset mid-operation aborts immediately. No finish is produced.
- States: IDLE, SQR, MUL, DONE.
- IDLE, start=1 (edge T):
  - Latch exp=d, mod=n.
  - base = c mod n.
  - acc = 1 mod n.
  - idx = 2*WIDTH-1.
  - busy=1. Next state is SQR, or DONE with err=1 and m=0 if n==0.
- SQR: acc = (acc*acc) mod mod.
  - If exp[idx]=1: next state MUL.
  - Else if idx==0: next state DONE.
  - Else: idx-1, stay in SQR.
- MUL: acc = (acc*base) mod mod.
  - If idx==0: next state DONE.
  - Else: idx-1, next state SQR.
- DONE: m=acc, finish=1 for this cycle only, busy deasserts at the end of the cycle, next state IDLE.
- Arithmetic:
  - Products are computed at 4*WIDTH bits, then reduced mod mod.
  - Each modular multiply completes in one cycle.
  - acc and base are always < mod.
- Latency: finish is high in cycle T+k, with k = 2*WIDTH + popcount(d) + 1. The n==0 case gives k=1.
- start while busy is ignored, and inputs changing while busy have no effect.
- start in the DONE cycle is ignored. start is accepted in IDLE on the following cycle.
- Boundary results:
  - d==0 gives m = 1 mod n.
  - n==1 gives m=0.
  - c>=n is reduced first.
  - c==0 with d>0 gives m=0.

Optional Feature:
- Macro: RSA_CONST_TIME_EN.
- Defined:
  - MUL is entered after every SQR regardless of exp[idx].
  - The product is always computed; acc is written only when exp[idx]=1, and otherwise the value goes to a dummy register.
  - k = 4*WIDTH + 1 for any d, so finish timing is independent of d.
- Undefined: the data-dependent schedule above (timing leaks popcount(d)).
- Results are identical in both builds.

Test Plan (WIDTH=8):
- Decryption:
  - Stimulus: c=2790, d=2753, n=3233, start pulse.
  - Response: m=65, err=0; finish at T+22, or T+33 with RSA_CONST_TIME_EN.
- Encryption:
  - Stimulus: c=65, d=17, n=3233.
  - Response: m=2790; finish at T+19, or T+33 with RSA_CONST_TIME_EN.
- Boundary values (checked separately):
  - d=0, n=3233 gives m=1.
  - c=5, d=3, n=1 gives m=0.
  - c=4000, d=1, n=3233 gives m=767.
- Error case:
  - Stimulus: n=0.
  - Response: finish and err at T+1, m=0.
  - A following start with n=3233 clears err.
- Handshake:
  - Stimulus: start re-pulsed with different c/d/n at T+5 and T+10 during the decryption case.
  - Response: the result is still m=65 at T+22, and only one finish is produced.
- Reset mid-operation:
  - Stimulus: rst_n low at T+8.
  - Response: m=0, busy=0, and no finish.
  - A fresh start afterwards completes normally.
- Constant-time build: two self-composed copies with equal c and n and d=2753 vs d=3 have equal finish cycles.
